servo_pwm_ctrl: RTL and testbench



---
 rtl/servo_pwm_ctrl.sv | 51 +++++
 tb/tb_servo_pwm_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/servo_pwm_ctrl.sv
// Hobby-servo PWM generator: fixed-length frame, clamped high pulse whose
// width is sampled once per frame at the frame boundary so the output never glitches.
module servo_pwm_ctrl #(
  parameter int unsigned FRAME_CYCLES = 2000000,
  parameter int unsigned MIN_PULSE    = 50000,
  parameter int unsigned MAX_PULSE    = 250000,
  parameter int unsigned CNT_WIDTH    = 21
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [23:0] i_Control_Range,
  output logic        o_Servo
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(FRAME_CYCLES - 1);
  localparam logic [23:0]          MIN_W      = 24'(MIN_PULSE);
  localparam logic [23:0]          MAX_W      = 24'(MAX_PULSE);

  logic [CNT_WIDTH-1:0] count;
  logic [23:0]          width;
  logic [23:0]          clamped;
  logic [23:0]          count_ext;
  logic                 frame_end;

  assign frame_end = (count == LAST_COUNT);
  assign count_ext = 24'(count);

  always_comb begin
    clamped = i_Control_Range;
    if (i_Control_Range < MIN_W)
      clamped = MIN_W;
    else if (i_Control_Range > MAX_W)
      clamped = MAX_W;
  end

  // The compare uses the pre-increment count, so the pulse starts one clock
  // after the counter reads zero and lasts exactly `width` clocks.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      count   <= '0;
      width   <= '0;
      o_Servo <= 1'b0;
    end else begin
      count   <= frame_end ? '0 : count + CNT_WIDTH'(1);
      if (frame_end)
        width <= clamped;
      o_Servo <= (count_ext < width);
    end
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Directed bench for servo_pwm_ctrl using a scaled-down frame so every
// frame can be sampled completely within a short run.
module tb_servo_pwm_ctrl;

  localparam int unsigned FRAME = 200;
  localparam int unsigned MINP  = 20;
  localparam int unsigned MAXP  = 80;
  localparam int unsigned CW    = 8;

  logic        clk;
  logic        rst_l;
  logic [23:0] ctrl;
  logic        servo;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          tick        = 0;
  int          last_rise   = -1;
  int          rise_gap    = 0;

  typedef struct {
    logic [23:0] val;
    int unsigned exp;
  } vec_t;

  vec_t vecs [11];

  servo_pwm_ctrl #(
    .FRAME_CYCLES(FRAME),
    .MIN_PULSE   (MINP),
    .MAX_PULSE   (MAXP),
    .CNT_WIDTH   (CW)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_l),
    .i_Control_Range(ctrl),
    .o_Servo        (servo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Samples one whole frame at negedges; optionally changes the input mid-frame.
  task automatic run_frame(input int change_at, input logic [23:0] new_val,
                           output int high, output int start, output int runs);
    logic prev;
    high  = 0;
    start = -1;
    runs  = 0;
    prev  = 1'b0;
    for (int i = 0; i < int'(FRAME); i++) begin
      if (i == change_at) ctrl = new_val;
      @(negedge clk);
      if (servo) begin
        high++;
        if (start < 0) start = i;
        if (!prev) begin
          runs++;
          if (last_rise >= 0) rise_gap = tick - last_rise;
          last_rise = tick;
        end
      end
      prev = servo;
      tick++;
    end
  endtask

  task automatic frame_check(input string tag, input int high, input int start,
                             input int runs, input int unsigned exp);
    check({tag, "_high"}, int'(high) >= 0 ? high : 0, exp);
    if (exp > 0) begin
      check({tag, "_start"}, start < 0 ? 999 : start, 0);
      check({tag, "_runs"}, runs, 1);
    end
  endtask

  initial begin
    int high, start, runs;
    int unsigned prev_exp;

    vecs = '{
      '{24'd50,       50}, '{24'd5,   20}, '{24'd0,  20}, '{24'd19,  20},
      '{24'd20,       20}, '{24'd21,  21}, '{24'd80, 80}, '{24'd81,  80},
      '{24'hFFFFFF,   80}, '{24'd79,  79}, '{24'd50, 50}
    };

    rst_l = 1'b0;
    ctrl  = 24'd50;
    repeat (3) @(negedge clk);
    check("reset_out", servo, 0);
    rst_l = 1'b1;

    run_frame(-1, '0, high, start, runs);
    check("first_frame_high", high, 0);

    // Each frame shows the width latched from the input held during the prior frame.
    prev_exp = 50;
    foreach (vecs[k]) begin
      ctrl = vecs[k].val;
      run_frame(-1, '0, high, start, runs);
      frame_check($sformatf("vec%0d", k), high, start, runs, prev_exp);
      prev_exp = vecs[k].exp;
    end

    run_frame(6, 24'd70, high, start, runs);
    frame_check("midchange_cur", high, start, runs, prev_exp);
    run_frame(-1, '0, high, start, runs);
    frame_check("midchange_next", high, start, runs, 70);

    repeat (10) @(negedge clk);
    check("pre_reset_high", servo, 1);
    rst_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in_reset%0d", i), servo, 0);
    end
    rst_l = 1'b1;
    run_frame(-1, '0, high, start, runs);
    check("post_reset_frame_high", high, 0);
    ctrl = 24'd60;
    run_frame(-1, '0, high, start, runs);
    frame_check("post_reset_resume", high, start, runs, 70);

    last_rise = -1;
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, '0, high, start, runs);
      frame_check($sformatf("period%0d", f), high, start, runs, 60);
      if (f > 0) check($sformatf("period%0d_gap", f), rise_gap, FRAME);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
